dispatch_queue_stage: RTL

Parametrised successor to the single-slot decode/rename stage. It buffers decoded instructions in a DEPTH-entry FIFO with a valid/ready handshake toward fetch/decode. For the head entry it renames registers through the map table and resolves operands from the regfile, ROB or completion bus. It then dispatches the head to one of NUM_RS reservation stations, allocating a ROB entry in the same cycle. It sits between the decoder and the reservation stations/ROB.

---
 rtl/dispatch_queue_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dispatch_queue_stage.sv
// Dispatch queue: a DEPTH-entry FIFO of decoded instructions that renames and resolves operands
// for the head entry and dispatches it to a reservation station. Optional DISPATCH_STALL_STATS_EN.
module dispatch_queue_stage #(
   parameter int unsigned ROBsize    = 8,
   parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
   parameter int unsigned NUM_RS     = 4,
   parameter int unsigned RS_SEL_W   = $clog2(NUM_RS),
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned CMD_W      = 10
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic                         instValid_i,
   output logic                         instReady_o,
   input  logic [4:0]                   instRN_i,
   input  logic [4:0]                   instRM_i,
   input  logic [4:0]                   instRD_i,
   input  logic [RS_SEL_W-1:0]          instRSsel_i,
   input  logic [CMD_W-1:0]             instCmd_i,
   input  logic [3:0]                   instType_i,
   input  logic [DATA_W-1:0]            instImm_i,
   input  logic                         instUseImm_i,
   input  logic                         instRegWrite_i,
   output logic [4:0]                   mapReadAddr1_o,
   output logic [4:0]                   mapReadAddr2_o,
   output logic [4:0]                   mapWriteAddr_o,
   input  logic [ROBsizeLog-1:0]        mapReadData1_i,
   input  logic [ROBsizeLog-1:0]        mapReadData2_i,
   output logic [ROBsizeLog-1:0]        mapWriteData_o,
   output logic                         mapRegWrite_o,
   output logic [4:0]                   regfileReadRegister1_o,
   output logic [4:0]                   regfileReadRegister2_o,
   input  logic [DATA_W-1:0]            regfileReadData1_i,
   input  logic [DATA_W-1:0]            regfileReadData2_i,
   output logic [ROBsizeLog-1:0]        robReadAddr1_o,
   output logic [ROBsizeLog-1:0]        robReadAddr2_o,
   input  logic [DATA_W:0]              robReadData1_i,
   input  logic [DATA_W:0]              robReadData2_i,
   input  logic [ROBsizeLog-1:0]        robNextTail_i,
   input  logic                         robFull_i,
   output logic                         robAlloc_o,
   output logic [8:0]                   robAllocData_o,
   input  logic                         cdbValid_i,
   input  logic [ROBsizeLog-1:0]        cdbTag_i,
   input  logic [DATA_W-1:0]            cdbValue_i,
   input  logic [NUM_RS-1:0]            rsFull_i,
   output logic [NUM_RS-1:0]            rsWriteEn_o,
   output logic [ROBsizeLog-1:0]        rsTag_o,
   output logic [ROBsizeLog-1:0]        rsSrcTag1_o,
   output logic [ROBsizeLog-1:0]        rsSrcTag2_o,
   output logic [DATA_W-1:0]            rsSrcVal1_o,
   output logic [DATA_W-1:0]            rsSrcVal2_o,
   output logic [CMD_W-1:0]             rsCmd_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [31:0]                  stallCycles_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [4:0]          rn;
      logic [4:0]          rm;
      logic [4:0]          rd;
      logic [RS_SEL_W-1:0] rs_sel;
      logic [CMD_W-1:0]    cmd;
      logic [3:0]          typ;
      logic [DATA_W-1:0]   imm;
      logic                use_imm;
      logic                reg_write;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             head;
   entry_t             wr_entry;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CNT_W-1:0]   count_q;
   logic               head_valid, push, fire, rs_free;

   assign head_valid  = (count_q != '0);
   assign instReady_o = reset_i & (count_q != CNT_W'(DEPTH));
   assign push        = instValid_i & instReady_o & ~flush_i;
   assign head        = mem_q[head_q];
   assign count_o     = count_q;

   assign wr_entry = '{rn: instRN_i, rm: instRM_i, rd: instRD_i, rs_sel: instRSsel_i,
                       cmd: instCmd_i, typ: instType_i, imm: instImm_i,
                       use_imm: instUseImm_i, reg_write: instRegWrite_i};

   // A select with no matching station leaves rs_free low, so the head never dispatches.
   always_comb begin
      rs_free = 1'b0;
      for (int unsigned i = 0; i < NUM_RS; i++) begin
         if (head.rs_sel == RS_SEL_W'(i)) rs_free = ~rsFull_i[i];
      end
   end

   assign fire = head_valid & ~robFull_i & rs_free & ~flush_i;

   always_comb begin
      rsWriteEn_o = '0;
      for (int unsigned i = 0; i < NUM_RS; i++) begin
         rsWriteEn_o[i] = fire & (head.rs_sel == RS_SEL_W'(i));
      end
   end

   assign mapReadAddr1_o         = head.rn;
   assign mapReadAddr2_o         = head.rm;
   assign regfileReadRegister1_o = head.rn;
   assign regfileReadRegister2_o = head.rm;
   assign robReadAddr1_o         = mapReadData1_i;
   assign robReadAddr2_o         = mapReadData2_i;

   assign robAlloc_o     = fire;
   assign robAllocData_o = {head.typ, head.rd};
   assign mapRegWrite_o  = fire & head.reg_write & (head.rd != 5'd31);
   assign mapWriteAddr_o = head.rd;
   assign mapWriteData_o = robNextTail_i;
   assign rsTag_o        = robNextTail_i;
   assign rsCmd_o        = head.cmd;

   // Sources read the map before this cycle's rename lands, so self-dependence sees the old tag.
   always_comb begin
      rsSrcVal1_o = '0;
      rsSrcTag1_o = mapReadData1_i;
      if (mapReadData1_i == '0) begin
         rsSrcVal1_o = regfileReadData1_i;
      end else if (cdbValid_i && (cdbTag_i == mapReadData1_i)) begin
         rsSrcVal1_o = cdbValue_i;
         rsSrcTag1_o = '0;
      end else if (robReadData1_i[DATA_W]) begin
         rsSrcVal1_o = robReadData1_i[DATA_W-1:0];
         rsSrcTag1_o = '0;
      end
   end

   always_comb begin
      rsSrcVal2_o = '0;
      rsSrcTag2_o = mapReadData2_i;
      if (head.use_imm) begin
         rsSrcVal2_o = head.imm;
         rsSrcTag2_o = '0;
      end else if (mapReadData2_i == '0) begin
         rsSrcVal2_o = regfileReadData2_i;
      end else if (cdbValid_i && (cdbTag_i == mapReadData2_i)) begin
         rsSrcVal2_o = cdbValue_i;
         rsSrcTag2_o = '0;
      end else if (robReadData2_i[DATA_W]) begin
         rsSrcVal2_o = robReadData2_i[DATA_W-1:0];
         rsSrcTag2_o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[tail_q] <= wr_entry;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= tail_q;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (fire) head_q <= head_q + PTR_W'(1);
         if (push && !fire) count_q <= count_q + CNT_W'(1);
         else if (!push && fire) count_q <= count_q - CNT_W'(1);
      end
   end

`ifdef DISPATCH_STALL_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         stall_q <= '0;
      end else if (head_valid && !fire && !flush_i && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stallCycles_o = stall_q;
`else
   assign stallCycles_o = '0;
`endif

endmodule
